// File: rtl/gayle_mc_if.sv
// CPU-side bus bundle for the Gayle interrupt/ID controller:
// address/data strobes, direction, address, data and cycle termination.
interface gayle_mc_if;
    logic        AS20;
    logic        DS20;
    logic        RW;
    logic [31:0] A;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        ACCESS;
    logic        ACK;

    modport master (
        output AS20, DS20, RW, A, D_IN,
        input  D_OUT, ACCESS, ACK
    );

    modport slave (
        input  AS20, DS20, RW, A, D_IN,
        output D_OUT, ACCESS, ACK
    );
endinterface

// File: rtl/gayle_mc.sv
// Gayle-style IDE interrupt controller with serial ID register.
// Decodes $DA8000-$DAFFFF (STAT/INTCHG/INTENA/INTMODE) and optionally $DE1xxx (ID),
// performs one register op per address strobe and terminates the cycle with ACK
// after WAIT_CYCLES clocks. Channel i maps onto data bit 7-i.
module gayle_mc #(
    parameter int         NCHAN        = 2,
    parameter logic [3:0] GAYLE_ID_VAL = 4'hD,
    parameter bit         ID_EN        = 1'b1,
    parameter int         WAIT_CYCLES  = 2
) (
    input  logic             CLKCPU,
    input  logic             RESET,
    gayle_mc_if.slave        bus,
    input  logic [NCHAN-1:0] IDE_INT,
    output logic             INT2
);
    localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [NCHAN-1:0] chg_q, chg_d;
    logic [NCHAN-1:0] ena_q, ena_d;
    logic [NCHAN-1:0] mode_q, mode_d;
    logic [NCHAN-1:0] last_q, last_d;
    logic [3:0]       id_q, id_d;
    logic [7:0]       dout_q, dout_d;
    // Set once AS20 has been seen negated; blocks a new op until the strobe
    // that was active across a reset or a finished cycle has gone away.
    logic             armed_q, armed_d;

    logic             hit_da, hit_id, op, rd_op, wr_op;
    logic [2:0]       sel;
    logic [NCHAN-1:0] din_ch, set_ev, chg_keep;
    logic             unused_bits;

    // Channel vector -> data byte (channel i on bit 7-i, rest zero).
    function automatic logic [7:0] chan_to_byte(input logic [NCHAN-1:0] v);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < NCHAN; i++) b[7-i] = v[i];
        return b;
    endfunction

    // Data byte -> channel vector (channel i from bit 7-i).
    function automatic logic [NCHAN-1:0] byte_to_chan(input logic [7:0] b);
        logic [NCHAN-1:0] v;
        for (int i = 0; i < NCHAN; i++) v[i] = b[7-i];
        return v;
    endfunction

    assign unused_bits = ^{bus.A[11:0], bus.D_IN};

    // Address decode and op-cycle qualification.
    always_comb begin
        hit_da = (bus.A[31:15] == {16'h00DA, 1'b1});
        hit_id = ID_EN && (bus.A[31:12] == 20'h00DE1);
        sel    = bus.A[14:12];
        din_ch = byte_to_chan(bus.D_IN);
        op     = (state_q == IDLE) && armed_q && (hit_da || hit_id) &&
                 !bus.AS20 && !bus.DS20;
        rd_op  = op && bus.RW;
        wr_op  = op && !bus.RW;
    end

    assign bus.ACCESS = ~(hit_da | hit_id);
    assign bus.ACK    = (state_q != DONE);
    assign bus.D_OUT  = dout_q;
    assign INT2       = ~|(chg_q & ena_q);

    // Register file next-state: reads, writes and interrupt latching.
    always_comb begin
        ena_d    = ena_q;
        mode_d   = mode_q;
        id_d     = id_q;
        dout_d   = dout_q;
        chg_keep = '1;
        last_d   = IDE_INT;

        if (rd_op) begin
            if (hit_id) begin
                dout_d = {id_q[3], 7'b0};
                id_d   = {id_q[2:0], 1'b1};
            end else begin
                case (sel)
                    3'b000:  dout_d = chan_to_byte(IDE_INT);
                    3'b001:  dout_d = chan_to_byte(chg_q);
                    3'b010:  dout_d = chan_to_byte(ena_q);
                    3'b011:  dout_d = chan_to_byte(mode_q);
                    default: dout_d = 8'h00;
                endcase
            end
        end

        if (wr_op) begin
            if (hit_id) begin
                id_d = GAYLE_ID_VAL;
            end else begin
                case (sel)
                    3'b001:  chg_keep = din_ch;
                    3'b010:  ena_d    = din_ch;
                    3'b011:  mode_d   = din_ch;
                    default: ;
                endcase
            end
        end

        // Edge mode needs a 0->1 transition, level mode just a high input;
        // OR-ing the set term last makes a set beat a same-edge clear.
        set_ev = ena_q & ((mode_q & IDE_INT) | (~mode_q & IDE_INT & ~last_q));
        chg_d  = (chg_q & chg_keep) | set_ev;
    end

    // Bus cycle FSM next-state: op, programmable wait, ACK until strobe release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;

        if (bus.AS20) armed_d = 1'b1;
        else if (op)  armed_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (op) begin
                    cnt_d   = WAIT_LD;
                    state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (bus.AS20) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.AS20) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register flops with asynchronous reset.
    always_ff @(posedge CLKCPU or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            chg_q   <= '0;
            ena_q   <= '0;
            mode_q  <= '0;
            last_q  <= '0;
            id_q    <= GAYLE_ID_VAL;
            dout_q  <= 8'h00;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
            ena_q   <= ena_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            id_q    <= id_d;
            dout_q  <= dout_d;
            armed_q <= armed_d;
        end
    end
endmodule

// File: tb/tb_gayle_mc.sv
// Bench for gayle_mc: directed scenarios followed by randomized bus traffic,
// checked every clock against a register-level model of the controller.
module tb_gayle_mc;
    localparam int NCHAN = 2;
    localparam int WC    = 2;
    localparam logic [31:0] A_STAT = 32'h00DA8000;
    localparam logic [31:0] A_CHG  = 32'h00DA9000;
    localparam logic [31:0] A_ENA  = 32'h00DAA000;
    localparam logic [31:0] A_MODE = 32'h00DAB000;
    localparam logic [31:0] A_RSV  = 32'h00DAC000;
    localparam logic [31:0] A_ID   = 32'h00DE1000;
    localparam logic [7:0]  CHMASK = 8'(8'hFF << (8 - NCHAN));

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCHAN-1:0] ide_int = '0;
    logic             int2;
    int               vectors = 0;
    int               miscompares = 0;
    bit               rand_irq = 1'b0;

    // model state, kept in data-byte form (channel i at bit 7-i)
    logic [7:0] m_chg, m_ena, m_mode, m_last, m_dout;
    int         m_id;

    gayle_mc_if bus ();

    gayle_mc #(
        .NCHAN(NCHAN), .GAYLE_ID_VAL(4'hD), .ID_EN(1'b1), .WAIT_CYCLES(WC)
    ) dut (
        .CLKCPU(clk), .RESET(rst), .bus(bus), .IDE_INT(ide_int), .INT2(int2)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] irq_byte();
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < NCHAN; i++) b[7-i] = ide_int[i];
        return b;
    endfunction

    // -1: no decode, 0..7: $DA register index, 8: ID register
    function automatic int region(input logic [31:0] a);
        if (a >= 32'h00DA8000 && a <= 32'h00DAFFFF) return int'((a - 32'h00DA8000) / 4096);
        if (a / 4096 == 32'h00000DE1) return 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_chg = 0; m_ena = 0; m_mode = 0; m_last = 0; m_dout = 0; m_id = 13;
    endtask

    task automatic model_edge(input bit op);
        logic [7:0] irq, set, nchg, nena, nmode;
        int r;
        if (rst) return;
        irq   = irq_byte();
        set   = m_ena & ((m_mode & irq) | (~m_mode & irq & ~m_last));
        nchg  = m_chg; nena = m_ena; nmode = m_mode;
        if (op) begin
            r = region(bus.A);
            if (bus.RW) begin
                case (r)
                    0: m_dout = irq;
                    1: m_dout = m_chg;
                    2: m_dout = m_ena;
                    3: m_dout = m_mode;
                    8: begin
                        m_dout = ((m_id / 8) % 2 == 1) ? 8'h80 : 8'h00;
                        m_id   = (m_id * 2 + 1) % 16;
                    end
                    default: m_dout = 8'h00;
                endcase
            end else begin
                case (r)
                    1: nchg  = m_chg & bus.D_IN;
                    2: nena  = bus.D_IN & CHMASK;
                    3: nmode = bus.D_IN & CHMASK;
                    8: m_id  = 13;
                    default: ;
                endcase
            end
        end
        m_chg = (nchg | set) & CHMASK;
        m_ena = nena; m_mode = nmode; m_last = irq;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One clock: update model at the edge, compare all outputs, return at negedge.
    task automatic tick(input bit op, input logic exp_ack);
        @(posedge clk);
        model_edge(op);
        #1;
        check("ACK", {7'b0, bus.ACK}, {7'b0, exp_ack});
        check("INT2", {7'b0, int2}, {7'b0, ((m_chg & m_ena) == 8'h00)});
        check("D_OUT", bus.D_OUT, m_dout);
        check("ACCESS", {7'b0, bus.ACCESS}, {7'b0, (region(bus.A) < 0)});
        @(negedge clk);
        if (rand_irq) ide_int = NCHAN'($urandom);
    endtask

    // Full cycle; hold = extra DONE clocks with DS20 toggling (must not re-trigger).
    task automatic bus_cycle(input logic rw, input logic [31:0] addr,
                             input logic [7:0] wd, input int hold);
        bus.A = addr; bus.RW = rw; bus.D_IN = wd; bus.AS20 = 0; bus.DS20 = 0;
        for (int j = 0; j <= WC + hold; j++) begin
            if (j > WC) bus.DS20 = ~bus.DS20;
            tick(j == 0, (j >= WC) ? 1'b0 : 1'b1);
        end
        bus.AS20 = 1; bus.DS20 = 1;
        tick(0, 1'b1);
    endtask

    // Strobe negated right after the op edge: no ACK, op stands.
    task automatic abort_cycle(input logic rw, input logic [31:0] addr, input logic [7:0] wd);
        bus.A = addr; bus.RW = rw; bus.D_IN = wd; bus.AS20 = 0; bus.DS20 = 0;
        tick(1, 1'b1);
        bus.AS20 = 1; bus.DS20 = 1;
        tick(0, 1'b1);
        tick(0, 1'b1);
    endtask

    initial begin
        logic [31:0] addrs [9];
        logic [4:0]  id_seq;
        int          r;
        logic [31:0] a;

        bus.AS20 = 1; bus.DS20 = 1; bus.RW = 1; bus.A = 0; bus.D_IN = 0;
        model_reset();
        @(negedge clk);
        tick(0, 1'b1);
        tick(0, 1'b1);
        rst = 0;
        tick(0, 1'b1);

        // address decode sweep, strobes idle
        addrs = '{32'h00DA8000, 32'h00DA7FFF, 32'h00DAFFFF, 32'h00DB0000, 32'h00DE1000,
                  32'h00DE1FFF, 32'h00DE2000, 32'h01DA8000, 32'h00DA8123};
        foreach (addrs[k]) begin
            bus.A = addrs[k];
            tick(0, 1'b1);
        end

        // ID shift sequence 1,1,0,1,1 then reload by write
        id_seq = 5'b11011;
        for (int k = 0; k < 5; k++) begin
            bus_cycle(1, A_ID, 8'h00, 0);
            check("ID_SEQ", bus.D_OUT, id_seq[4-k] ? 8'h80 : 8'h00);
        end
        bus_cycle(0, A_ID, 8'h00, 0);
        bus_cycle(1, A_ID, 8'h00, 0);
        check("ID_RELOAD", bus.D_OUT, 8'h80);

        // edge mode on channel 1, write-0-to-clear
        bus_cycle(0, A_ENA, 8'hC0, 0);
        ide_int = 2'b10;
        tick(0, 1'b1);
        bus_cycle(1, A_CHG, 8'h00, 0);
        check("CHG_EDGE", bus.D_OUT, 8'h40);
        check("INT2_SET", {7'b0, int2}, 8'h00);
        bus_cycle(0, A_CHG, 8'hBF, 0);
        bus_cycle(1, A_CHG, 8'h00, 0);
        check("CHG_CLR", bus.D_OUT, 8'h00);
        check("INT2_CLR", {7'b0, int2}, 8'h01);

        // level mode on channel 0: set wins over a clearing write
        ide_int = 2'b00;
        bus_cycle(0, A_ENA, 8'h00, 0);
        bus_cycle(0, A_MODE, 8'h80, 0);
        bus_cycle(0, A_ENA, 8'h80, 0);
        ide_int = 2'b01;
        tick(0, 1'b1);
        bus_cycle(0, A_CHG, 8'h00, 0);
        bus_cycle(1, A_CHG, 8'h00, 0);
        check("CHG_LEVEL", bus.D_OUT, 8'h80);

        // masking keeps the pending bit
        bus_cycle(0, A_ENA, 8'h00, 0);
        check("INT2_MASK", {7'b0, int2}, 8'h01);
        bus_cycle(1, A_CHG, 8'h00, 0);
        check("CHG_MASKED", bus.D_OUT, 8'h80);

        // live status, reserved and ignored writes, held strobe with DS toggling
        bus_cycle(1, A_STAT, 8'h00, 2);
        check("STAT", bus.D_OUT, 8'h80);
        bus_cycle(0, A_STAT, 8'hFF, 0);
        bus_cycle(0, A_RSV, 8'hFF, 0);
        bus_cycle(1, A_RSV, 8'h00, 0);
        check("RSV", bus.D_OUT, 8'h00);
        bus_cycle(1, A_ID, 8'h00, 3);
        bus_cycle(1, A_ID, 8'h00, 0);

        // abort in WAIT, then the aborted ID read must have shifted
        abort_cycle(1, A_ID, 8'h00);
        bus_cycle(1, A_ID, 8'h00, 0);

        // reset while ACK is asserted; no ACK for the interrupted strobe
        bus_cycle(0, A_ENA, 8'h80, 0);
        bus.A = A_ENA; bus.RW = 1; bus.AS20 = 0; bus.DS20 = 0;
        tick(1, 1'b1);
        tick(0, 1'b1);
        tick(0, 1'b0);
        rst = 1;
        model_reset();
        #1;
        check("RST_ACK", {7'b0, bus.ACK}, 8'h01);
        check("RST_INT2", {7'b0, int2}, 8'h01);
        check("RST_DOUT", bus.D_OUT, 8'h00);
        tick(0, 1'b1);
        rst = 0;
        for (int k = 0; k < 3; k++) tick(0, 1'b1);
        bus.AS20 = 1; bus.DS20 = 1;
        tick(0, 1'b1);
        bus_cycle(1, A_ENA, 8'h00, 0);
        check("RST_ENA", bus.D_OUT, 8'h00);
        bus_cycle(1, A_ID, 8'h00, 0);
        check("RST_ID", bus.D_OUT, 8'h80);

        // randomized traffic with toggling interrupt inputs
        rand_irq = 1'b1;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 8);
            a = (r == 8) ? A_ID : (32'h00DA8000 + 32'(r) * 32'h1000);
            a = a + 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0)
                abort_cycle(1'($urandom_range(0, 1)), a, 8'($urandom));
            else
                bus_cycle(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, 2));
        end
        rand_irq = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gayle_mc.md
GAYLE_MC -- requirements
Module: gayle_mc

Interface
REQ-001 Parameter NCHAN, default 2: number of IDE interrupt channels, legal range 1..4.
REQ-002 Parameter GAYLE_ID_VAL, default 4'hD: 4-bit ID value shifted out by the ID register.
REQ-003 Parameter ID_EN, default 1: 1 decodes the ID register at $DE1xxx; 0 removes the ID decode.
REQ-004 Parameter WAIT_CYCLES, default 2: CLKCPU cycles from op cycle to ACK assertion, legal range 0..7.
REQ-005 CLKCPU  in  1  sole clock; all state changes on its rising edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 AS20  in  1  active-low address strobe.
REQ-008 DS20  in  1  active-low data strobe.
REQ-009 RW  in  1  1 = read, 0 = write.
REQ-010 A  in  32  CPU address.
REQ-011 IDE_INT  in  NCHAN  active-high interrupt request, one bit per channel.
REQ-012 D_IN  in  8  write data; channel i uses bit 7-i.
REQ-013 D_OUT  out  8  registered read data; channel i on bit 7-i; unused bits 0.
REQ-014 ACCESS  out  1  active-low combinational decode hit.
REQ-015 ACK  out  1  active-low cycle termination.
REQ-016 INT2  out  1  active-low interrupt request to Paula.

Function
REQ-017 ACCESS SHALL be 0 when A[31:15]=={16'h00DA,1'b1}, or when ID_EN=1 and A[31:12]==20'h00DE1; otherwise 1.
REQ-018 Register select for the $DAxxxx window is A[14:12]: 000 STAT, 001 INTCHG, 010 INTENA, 011 INTMODE; 1xx is reserved and reads 8'h00 with writes ignored.
REQ-019 The FSM SHALL have states IDLE, WAIT and DONE, and SHALL reset to IDLE.
REQ-020 IDLE->op cycle: when ACCESS=0, AS20=0 and DS20=0 at a clock edge, the FSM SHALL perform exactly one register op at that edge and load the wait counter with WAIT_CYCLES.
REQ-021 From the op cycle, the FSM SHALL go to DONE if WAIT_CYCLES=0; otherwise it SHALL go to WAIT.
REQ-022 WAIT: the counter SHALL decrement each cycle, and the FSM SHALL enter DONE when the counter reaches 1.
REQ-023 ACK SHALL be 0 exactly while the FSM is in DONE.
REQ-024 DONE: the FSM SHALL hold until AS20=1 is sampled, then return to IDLE; no second op SHALL occur within one AS20 assertion.
REQ-025 If AS20=1 is sampled in WAIT, the FSM SHALL abort to IDLE with no ACK; the op already performed SHALL stand.
REQ-026 STAT read SHALL return the live IDE_INT bits.
REQ-027 INTCHG read SHALL return INTCHG.
REQ-028 INTENA read SHALL return INTENA.
REQ-029 INTMODE read SHALL return INTMODE.
REQ-030 ID read SHALL return id[3] on D_OUT[7], with other bits 0, and SHALL shift id left with a 1 fill.
REQ-031 An ID write SHALL reload id with GAYLE_ID_VAL.
REQ-032 D_OUT SHALL update only on read op cycles and SHALL hold its value between reads.
REQ-033 An INTENA write SHALL load the channel bits from D_IN.
REQ-034 An INTMODE write SHALL load the channel bits from D_IN; 0 = edge mode, 1 = level mode.
REQ-035 An INTCHG write SHALL set INTCHG[i] to INTCHG[i] AND D_IN[7-i] (write-0-to-clear).
REQ-036 intlast[i] SHALL register IDE_INT[i] every cycle.
REQ-037 Set event for channel i: INTENA[i]=1 and either (edge mode and IDE_INT[i]=1 with intlast[i]=0) or (level mode and IDE_INT[i]=1).
REQ-038 When a set event and a clearing INTCHG write hit the same bit on the same edge, the set SHALL win.
REQ-039 A STAT write SHALL be ignored.
REQ-040 INT2 SHALL be the inverse of OR over i of (INTCHG[i] AND INTENA[i]), combinational from registers.
REQ-041 Clearing INTENA[i] SHALL mask INT2 for channel i without clearing INTCHG[i].

Reset
REQ-042 While RESET=1, the block SHALL hold: FSM IDLE, counter 0, INTCHG 0, INTENA 0, INTMODE 0, intlast 0, id = GAYLE_ID_VAL, D_OUT 8'h00, ACK 1, INT2 1.
REQ-043 RESET asserted mid-cycle SHALL return the FSM to IDLE immediately; an ACK SHALL NOT be issued for the interrupted cycle after reset release.

Verification
REQ-044 Reset; read $DE1000 five times -> D_OUT[7] reads 1,1,0,1,1 (GAYLE_ID_VAL=4'hD); write $DE1000, then read -> 1.
REQ-045 INTENA=8'hC0, IDE_INT rises on ch1 -> INTCHG=8'h40, INT2=0; write INTCHG 8'hBF -> INTCHG=8'h00, INT2=1 while IDE_INT stays high (edge mode).
REQ-046 INTMODE=8'h80, INTENA=8'h80, IDE_INT[0] held high, INTCHG written 8'h00 -> INTCHG reads 8'h80 again (level mode re-set, set wins).
REQ-047 WAIT_CYCLES=2 read of $DA8000 -> ACK low on the 2nd edge after the op edge and held until AS20 high; second read in the same AS20 assertion produces no op.
REQ-048 AS20 negated during WAIT -> no ACK, FSM IDLE; RESET pulse during DONE -> ACK=1 immediately, all registers at reset values.
